step_ctrl: RTL and testbench

Debug-unit step generator driving the `i_step` enable of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB). It decodes one-byte commands from the UART receive path and runs the pipeline either continuously until a HALT instruction retires, or one clock at a time. After each stop it requests a register/memory dump and waits for the dump to complete.

---
 rtl/debug_pkg.sv | 20 ++
 rtl/step_counter.sv | 30 +++
 rtl/step_ctrl.sv | 96 +++++++++
 tb/tb_step_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug-unit command codes and step controller states
package debug_pkg;

  localparam int NB_CMD = 8;

  localparam logic [NB_CMD-1:0] CMD_RUN   = 8'h63;
  localparam logic [NB_CMD-1:0] CMD_STEP  = 8'h73;
  localparam logic [NB_CMD-1:0] CMD_RESET = 8'h72;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DREQ,
    DWAIT,
    HALTED,
    CLR
  } step_state_e;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - stepped-cycle counter with enable and synchronous clear
module step_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [NB_CNT-1:0] o_count
);

  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;

  // Wraps silently modulo 2^NB_CNT
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    cnt_q <= cnt_d;
  end

  assign o_count = cnt_q;

endmodule

// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - debug-unit pipeline step generator with dump handshake
module step_ctrl
  import debug_pkg::*;
#(
  parameter int NB_CMD = debug_pkg::NB_CMD,
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [NB_CMD-1:0] i_cmd,
  input  logic              i_halt,
  input  logic              i_dump_done,
  output logic              o_step,
  output logic              o_pipe_reset,
  output logic              o_dump_req,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic              o_halted,
  output logic              o_busy,
  output logic              o_err
);

  step_state_e state_q, state_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd == NB_CMD'(CMD_RUN))        state_d = RUN;
          else if (i_cmd == NB_CMD'(CMD_STEP))  state_d = STEP;
          else if (i_cmd == NB_CMD'(CMD_RESET)) state_d = CLR;
          else                                  err_d   = 1'b1;
        end
      end
      RUN: begin
        if (i_halt) begin
          halted_d = 1'b1;
          state_d  = DREQ;
        end
      end
      STEP: begin
        if (i_halt) halted_d = 1'b1;
        state_d = DREQ;
      end
      DREQ: state_d = DWAIT;
      DWAIT: begin
        if (i_dump_done) state_d = halted_q ? HALTED : IDLE;
      end
      // Only a reset command can leave HALTED; everything else is dropped quietly
      HALTED: begin
        if (i_cmd_valid && (i_cmd == NB_CMD'(CMD_RESET))) state_d = CLR;
      end
      CLR: begin
        halted_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_step       = (state_q == RUN) || (state_q == STEP);
    o_pipe_reset = (state_q == CLR);
    o_dump_req   = (state_q == DREQ);
    o_halted     = (state_q == HALTED);
    o_busy       = (state_q != IDLE) && (state_q != HALTED);
    o_err        = err_q;
  end

  step_counter #(
    .NB_CNT(NB_CNT)
  ) u_step_counter (
    .i_clk  (i_clk),
    .i_clr  (i_reset || (state_q == CLR)),
    .i_en   (o_step),
    .o_count(o_cycle_count)
  );

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - scoreboard bench for step_ctrl
module tb_step_ctrl;

  localparam logic [7:0] C_RUN   = 8'h63;
  localparam logic [7:0] C_STEP  = 8'h73;
  localparam logic [7:0] C_RESET = 8'h72;
  localparam logic [7:0] C_BAD   = 8'h41;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic        halt = 1'b0;
  logic        dump_done = 1'b0;
  logic        o_step, o_pipe_reset, o_dump_req, o_halted, o_busy, o_err;
  logic [31:0] o_cycle_count;

  logic        cmd_valid_w = 1'b0;
  logic [7:0]  cmd_w = 8'h00;
  logic        halt_w = 1'b0;
  logic        step_w, pipe_reset_w, dump_req_w, halted_w, busy_w, err_w;
  logic [3:0]  count_w;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  step_ctrl #(.NB_CMD(8), .NB_CNT(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_halt(halt), .i_dump_done(dump_done), .o_step(o_step),
    .o_pipe_reset(o_pipe_reset), .o_dump_req(o_dump_req),
    .o_cycle_count(o_cycle_count), .o_halted(o_halted), .o_busy(o_busy),
    .o_err(o_err)
  );

  step_ctrl #(.NB_CMD(8), .NB_CNT(4)) dut_w (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(cmd_valid_w), .i_cmd(cmd_w),
    .i_halt(halt_w), .i_dump_done(1'b0), .o_step(step_w),
    .o_pipe_reset(pipe_reset_w), .o_dump_req(dump_req_w),
    .o_cycle_count(count_w), .o_halted(halted_w), .o_busy(busy_w),
    .o_err(err_w)
  );

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    i_reset = 1'b1;
    step_clk();
    i_reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd = b;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic expect_cnt(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: count got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_dump(input string name);
    int e;
    n_tests++;
    if (o_dump_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s dump_req: got %b want 1", name, o_dump_req);
    end else begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard: got empty queue want an entry", name);
      end else begin
        e = exp_q.pop_front();
        if (o_cycle_count !== 32'(e)) begin
          n_fail++;
          $display("FAIL %s dump count: got %0d want %0d", name, o_cycle_count, e);
        end
      end
    end
  endtask

  // Starts in the first stepped cycle; raises halt on the n-th and can inject a STEP byte mid-run
  task automatic run_steps(input int n, input int inject_at, input string name);
    for (int i = 1; i <= n; i++) begin
      n_tests++;
      if (o_step !== 1'b1) begin
        n_fail++;
        $display("FAIL %s step cycle %0d: got %b want 1", name, i, o_step);
      end
      if (i == inject_at) begin
        cmd_valid = 1'b1;
        cmd = C_STEP;
      end
      if (i == n) halt = 1'b1;
      step_clk();
      cmd_valid = 1'b0;
      halt = 1'b0;
    end
    expect_bit({name, " step_low"}, o_step, 1'b0);
    check_dump(name);
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    step_clk();
    step_clk();
    i_reset = 1'b0;
    n_tests++;
    if ({o_step, o_pipe_reset, o_dump_req, o_halted, o_busy, o_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 000000",
               {o_step, o_pipe_reset, o_dump_req, o_halted, o_busy, o_err});
    end
    expect_cnt("reset", o_cycle_count, 32'd0);
  endtask

  task automatic test_single_step;
    do_reset();
    exp_q.push_back(1);
    send(C_STEP);
    expect_bit("single step_hi", o_step, 1'b1);
    expect_bit("single busy", o_busy, 1'b1);
    step_clk();
    expect_bit("single step_lo", o_step, 1'b0);
    check_dump("single");
    step_clk();
    expect_bit("single dwait_no_req", o_dump_req, 1'b0);
    expect_bit("single dwait_busy", o_busy, 1'b1);
    dump_done = 1'b1;
    step_clk();
    dump_done = 1'b0;
    expect_bit("single idle_busy", o_busy, 1'b0);
    expect_bit("single idle_halted", o_halted, 1'b0);
    expect_cnt("single final", o_cycle_count, 32'd1);
  endtask

  task automatic test_run_to_halt;
    do_reset();
    exp_q.push_back(6);
    send(C_RUN);
    run_steps(6, 0, "run");
    dump_done = 1'b1;
    step_clk();
    dump_done = 1'b0;
    expect_bit("run done_in_dreq_ignored", o_busy, 1'b1);
    dump_done = 1'b1;
    step_clk();
    dump_done = 1'b0;
    expect_bit("run halted", o_halted, 1'b1);
    expect_bit("run busy", o_busy, 1'b0);
    expect_cnt("run final", o_cycle_count, 32'd6);
  endtask

  task automatic test_halted_lock;
    send(C_RUN);
    expect_bit("lock no_step", o_step, 1'b0);
    expect_bit("lock still_halted", o_halted, 1'b1);
    send(C_BAD);
    expect_bit("lock no_err", o_err, 1'b0);
    send(C_RESET);
    expect_bit("lock pipe_reset", o_pipe_reset, 1'b1);
    expect_bit("lock clr_busy", o_busy, 1'b1);
    step_clk();
    expect_bit("lock pipe_reset_end", o_pipe_reset, 1'b0);
    expect_bit("lock halted_clr", o_halted, 1'b0);
    expect_bit("lock idle", o_busy, 1'b0);
    expect_cnt("lock count_clr", o_cycle_count, 32'd0);
  endtask

  task automatic test_unknown;
    do_reset();
    send(C_BAD);
    expect_bit("unknown err", o_err, 1'b1);
    expect_bit("unknown busy", o_busy, 1'b0);
    expect_bit("unknown step", o_step, 1'b0);
    step_clk();
    expect_bit("unknown err_pulse", o_err, 1'b0);
    send(C_STEP);
    expect_bit("unknown still_idle", o_step, 1'b1);
  endtask

  task automatic test_busy_drop;
    do_reset();
    exp_q.push_back(5);
    send(C_RUN);
    run_steps(5, 3, "busy_drop");
    expect_bit("busy_drop no_err", o_err, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    send(C_RUN);
    step_clk();
    step_clk();
    step_clk();
    expect_cnt("midrun pre", o_cycle_count, 32'd3);
    i_reset = 1'b1;
    step_clk();
    i_reset = 1'b0;
    n_tests++;
    if ({o_step, o_pipe_reset, o_dump_req, o_halted, o_busy, o_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrun outputs: got %b want 000000",
               {o_step, o_pipe_reset, o_dump_req, o_halted, o_busy, o_err});
    end
    expect_cnt("midrun count", o_cycle_count, 32'd0);
    step_clk();
    expect_bit("midrun idle", o_step, 1'b0);
  endtask

  task automatic test_wrap;
    int e;
    logic err_seen;
    err_seen = 1'b0;
    do_reset();
    exp_q.push_back(17 % 16);
    cmd_valid_w = 1'b1;
    cmd_w = C_RUN;
    step_clk();
    cmd_valid_w = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      n_tests++;
      if (step_w !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap step cycle %0d: got %b want 1", i, step_w);
      end
      err_seen = err_seen | err_w;
      if (i == 17) halt_w = 1'b1;
      step_clk();
      halt_w = 1'b0;
    end
    expect_bit("wrap dump_req", dump_req_w, 1'b1);
    e = exp_q.pop_front();
    n_tests++;
    if (count_w !== 4'(e)) begin
      n_fail++;
      $display("FAIL wrap count: got %0d want %0d", count_w, e);
    end
    expect_bit("wrap no_err", err_seen | err_w, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_run_to_halt();
    test_halted_lock();
    test_unknown();
    test_busy_drop();
    test_reset_mid_run();
    test_wrap();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
